// File: rtl/branch_predictor.sv
`default_nettype none
// ============================================================================
// Module  : branch_predictor
// Brief   : IF-stage 2-bit counter direction predictor with tagged BTB and
//           EX-stage resolution (flush/redirect, statistics counters).
//           Optional gshare counter hashing: BRANCH_PREDICTOR_GSHARE_EN.
// Rev     : 1.0  initial release
// ============================================================================
module branch_predictor #(
    parameter int         INDEX_BITS = 6,
    parameter int         TAG_BITS   = 8,
    parameter logic [1:0] CNT_INIT   = 2'b01
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_if,
    output logic        predict_taken,
    output logic [31:0] predict_target,
    input  logic        ex_valid,
    input  logic [31:0] ex_pc4,
    input  logic        ex_taken,
    input  logic [31:0] ex_target,
    input  logic        ex_predicted,
    input  logic [31:0] ex_pred_target,
    output logic        miss_prediction,
    output logic [31:0] correct_pc,
    output logic [15:0] branch_cnt,
    output logic [15:0] miss_cnt
);

    localparam int          ENTRIES = 1 << INDEX_BITS;
    localparam int          TAG_LO  = INDEX_BITS + 2;
    localparam int          TAG_HI  = INDEX_BITS + TAG_BITS + 1;
    localparam logic [15:0] C_STAT_MAX = 16'hFFFF;

    logic [ENTRIES-1:0][1:0]   r_cnt;
    logic [ENTRIES-1:0]        r_valid;
    logic [TAG_BITS-1:0]       r_tag    [ENTRIES];
    logic [31:0]               r_target [ENTRIES];

    logic [INDEX_BITS-1:0]     w_lk_idx;
    logic [INDEX_BITS-1:0]     w_lk_cidx;
    logic [INDEX_BITS-1:0]     w_up_idx;
    logic [INDEX_BITS-1:0]     w_up_cidx;
    logic [TAG_BITS-1:0]       w_lk_tag;
    logic [TAG_BITS-1:0]       w_up_tag;
    logic [31:0]               w_bpc;
    logic                      w_hit;
    logic [1:0]                w_cnt_old;
    logic [1:0]                w_cnt_new;
    logic                      w_unused_bits;

    assign w_bpc    = ex_pc4 - 32'd4;
    assign w_lk_idx = pc_if[INDEX_BITS+1:2];
    assign w_lk_tag = pc_if[TAG_HI:TAG_LO];
    assign w_up_idx = w_bpc[INDEX_BITS+1:2];
    assign w_up_tag = w_bpc[TAG_HI:TAG_LO];

    assign w_unused_bits = ^{pc_if[31:TAG_HI+1], pc_if[1:0], w_bpc[31:TAG_HI+1], w_bpc[1:0]};

`ifdef BRANCH_PREDICTOR_GSHARE_EN
    logic [INDEX_BITS-1:0] r_ghr;

    // Counters are hashed with history; the BTB keeps the plain PC index.
    assign w_lk_cidx = w_lk_idx ^ r_ghr;
    assign w_up_cidx = w_up_idx ^ r_ghr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ghr <= '0;
        end else if (ex_valid) begin
            r_ghr <= {r_ghr[INDEX_BITS-2:0], ex_taken};
        end
    end
`else
    assign w_lk_cidx = w_lk_idx;
    assign w_up_cidx = w_up_idx;
`endif

    // Lookup reads registered state only, so a same-cycle update is not visible.
    assign w_hit          = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
    assign predict_taken  = w_hit && r_cnt[w_lk_cidx][1];
    assign predict_target = w_hit ? r_target[w_lk_idx] : 32'd0;

    assign miss_prediction = !rst && ex_valid &&
                             ((ex_taken != ex_predicted) ||
                              (ex_taken && ex_predicted && (ex_target != ex_pred_target)));
    assign correct_pc      = (ex_valid && ex_taken) ? ex_target : ex_pc4;

    assign w_cnt_old = r_cnt[w_up_cidx];

    always_comb begin
        w_cnt_new = w_cnt_old;
        if (ex_taken) begin
            if (w_cnt_old != 2'd3) w_cnt_new = w_cnt_old + 2'd1;
        end else begin
            if (w_cnt_old != 2'd0) w_cnt_new = w_cnt_old - 2'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt      <= {ENTRIES{CNT_INIT}};
            r_valid    <= '0;
            branch_cnt <= '0;
            miss_cnt   <= '0;
        end else if (ex_valid) begin
            r_cnt[w_up_cidx] <= w_cnt_new;
            if (ex_taken) r_valid[w_up_idx] <= 1'b1;
            if (branch_cnt != C_STAT_MAX) branch_cnt <= branch_cnt + 16'd1;
            if (miss_prediction && (miss_cnt != C_STAT_MAX)) miss_cnt <= miss_cnt + 16'd1;
        end
    end

    // Tag/target need no reset: r_valid gates every use of them.
    always_ff @(posedge clk) begin
        if (!rst && ex_valid && ex_taken) begin
            r_tag[w_up_idx]    <= w_up_tag;
            r_target[w_up_idx] <= ex_target;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_branch_predictor.sv
`default_nettype none
// Self-checking bench for branch_predictor: hand-derived vector table,
// randomized traffic against a behavioural model, and counter saturation.
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_if;
    logic        predict_taken;
    logic [31:0] predict_target;
    logic        ex_valid;
    logic [31:0] ex_pc4;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic        ex_predicted;
    logic [31:0] ex_pred_target;
    logic        miss_prediction;
    logic [31:0] correct_pc;
    logic [15:0] branch_cnt;
    logic [15:0] miss_cnt;

    always #5 clk = ~clk;

    branch_predictor dut (
        .clk            (clk),
        .rst            (rst),
        .pc_if          (pc_if),
        .predict_taken  (predict_taken),
        .predict_target (predict_target),
        .ex_valid       (ex_valid),
        .ex_pc4         (ex_pc4),
        .ex_taken       (ex_taken),
        .ex_target      (ex_target),
        .ex_predicted   (ex_predicted),
        .ex_pred_target (ex_pred_target),
        .miss_prediction(miss_prediction),
        .correct_pc     (correct_pc),
        .branch_cnt     (branch_cnt),
        .miss_cnt       (miss_cnt)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    int          m_cnt [64];
    bit          m_vld [64];
    int          m_tag [64];
    logic [31:0] m_tgt [64];
    int          m_ghr;
    int          m_br;
    int          m_miss;

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc / 4) % 64);
    endfunction

    function automatic int tag_of(input logic [31:0] pc);
        return int'((pc / 256) % 256);
    endfunction

    function automatic int cidx_of(input logic [31:0] pc);
`ifdef BRANCH_PREDICTOR_GSHARE_EN
        return idx_of(pc) ^ m_ghr;
`else
        return idx_of(pc);
`endif
    endfunction

    function automatic bit m_hit(input logic [31:0] pc);
        return m_vld[idx_of(pc)] && (m_tag[idx_of(pc)] == tag_of(pc));
    endfunction

    function automatic bit m_pred(input logic [31:0] pc);
        return m_hit(pc) && (m_cnt[cidx_of(pc)] >= 2);
    endfunction

    function automatic logic [31:0] m_ptgt(input logic [31:0] pc);
        return m_hit(pc) ? m_tgt[idx_of(pc)] : 32'd0;
    endfunction

    function automatic bit m_missed();
        if (!ex_valid) return 1'b0;
        return (ex_taken != ex_predicted) ||
               (ex_taken && ex_predicted && (ex_target != ex_pred_target));
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 64; i++) begin
            m_cnt[i] = 1;
            m_vld[i] = 1'b0;
            m_tag[i] = 0;
            m_tgt[i] = 32'd0;
        end
        m_ghr  = 0;
        m_br   = 0;
        m_miss = 0;
    endtask

    task automatic model_update();
        logic [31:0] bpc;
        int c;
        if (!ex_valid) return;
        bpc = ex_pc4 - 32'd4;
        c   = cidx_of(bpc);
        m_cnt[c] = ex_taken ? ((m_cnt[c] + 1 > 3) ? 3 : m_cnt[c] + 1)
                            : ((m_cnt[c] - 1 < 0) ? 0 : m_cnt[c] - 1);
        if (ex_taken) begin
            m_vld[idx_of(bpc)] = 1'b1;
            m_tag[idx_of(bpc)] = tag_of(bpc);
            m_tgt[idx_of(bpc)] = ex_target;
        end
        if (m_missed()) m_miss = (m_miss < 65535) ? m_miss + 1 : 65535;
        m_br  = (m_br < 65535) ? m_br + 1 : 65535;
        m_ghr = ((m_ghr * 2) + int'(ex_taken)) % 64;
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".predict_taken"},   {31'd0, predict_taken},   {31'd0, m_pred(pc_if)});
        chk({tag, ".predict_target"},  predict_target,           m_ptgt(pc_if));
        chk({tag, ".miss_prediction"}, {31'd0, miss_prediction}, {31'd0, m_missed()});
        chk({tag, ".correct_pc"},      correct_pc,               (ex_valid && ex_taken) ? ex_target : ex_pc4);
        chk({tag, ".branch_cnt"},      {16'd0, branch_cnt},      32'(m_br));
        chk({tag, ".miss_cnt"},        {16'd0, miss_cnt},        32'(m_miss));
    endtask

    // ---------------- hand-derived vector table ----------------
    typedef struct {
        logic [31:0] pc;
        logic        v;
        logic [31:0] pc4;
        logic        tk;
        logic [31:0] tgt;
        logic        pd;
        logic [31:0] ptgt;
        logic        e_pt;
        logic [31:0] e_ptgt;
        logic        e_miss;
        logic [31:0] e_cpc;
    } vec_t;

    vec_t vecs [15];

    initial begin
        //            pc       v  pc4      tk tgt      pd ptgt    | pt ptgt     miss cpc
        vecs[0]  = '{32'h40,  0, 32'h0,   0, 32'h0,   0, 32'h0,    0, 32'h0,   0, 32'h0};
        vecs[1]  = '{32'h40,  1, 32'h44,  1, 32'h80,  0, 32'h0,    0, 32'h0,   1, 32'h80};
        vecs[2]  = '{32'h40,  0, 32'h44,  0, 32'h0,   0, 32'h0,    1, 32'h80,  0, 32'h44};
        vecs[3]  = '{32'h40,  1, 32'h44,  1, 32'h80,  1, 32'h80,   1, 32'h80,  0, 32'h80};
        vecs[4]  = '{32'h40,  1, 32'h44,  1, 32'h80,  1, 32'h80,   1, 32'h80,  0, 32'h80};
        vecs[5]  = '{32'h40,  1, 32'h44,  1, 32'h80,  1, 32'h80,   1, 32'h80,  0, 32'h80};
        vecs[6]  = '{32'h40,  1, 32'h44,  1, 32'h80,  1, 32'h80,   1, 32'h80,  0, 32'h80};
        vecs[7]  = '{32'h40,  1, 32'h44,  0, 32'h80,  1, 32'h80,   1, 32'h80,  1, 32'h44};
        vecs[8]  = '{32'h40,  0, 32'h44,  0, 32'h0,   0, 32'h0,    1, 32'h80,  0, 32'h44};
        vecs[9]  = '{32'h40,  1, 32'h44,  1, 32'hC0,  1, 32'h80,   1, 32'h80,  1, 32'hC0};
        vecs[10] = '{32'h40,  0, 32'h44,  0, 32'h0,   0, 32'h0,    1, 32'hC0,  0, 32'h44};
        vecs[11] = '{32'h140, 0, 32'h44,  0, 32'h0,   0, 32'h0,    0, 32'h0,   0, 32'h44};
        vecs[12] = '{32'h40,  1, 32'h144, 1, 32'h200, 0, 32'h0,    1, 32'hC0,  1, 32'h200};
        vecs[13] = '{32'h40,  0, 32'h44,  0, 32'h0,   0, 32'h0,    0, 32'h0,   0, 32'h44};
        vecs[14] = '{32'h140, 0, 32'h44,  0, 32'h0,   0, 32'h0,    1, 32'h200, 0, 32'h44};
    end

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        pc_if = 32'h40; ex_valid = 1'b0; ex_pc4 = 32'd0; ex_taken = 1'b0;
        ex_target = 32'd0; ex_predicted = 1'b0; ex_pred_target = 32'd0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset.predict_taken",   {31'd0, predict_taken},   32'd0);
        chk("reset.predict_target",  predict_target,           32'd0);
        chk("reset.miss_prediction", {31'd0, miss_prediction}, 32'd0);
        chk("reset.branch_cnt",      {16'd0, branch_cnt},      32'd0);
        chk("reset.miss_cnt",        {16'd0, miss_cnt},        32'd0);
        rst = 1'b0;

`ifndef BRANCH_PREDICTOR_GSHARE_EN
        for (int i = 0; i < 15; i++) begin
            pc_if = vecs[i].pc;   ex_valid = vecs[i].v;  ex_pc4 = vecs[i].pc4;
            ex_taken = vecs[i].tk; ex_target = vecs[i].tgt;
            ex_predicted = vecs[i].pd; ex_pred_target = vecs[i].ptgt;
            #1;
            chk($sformatf("vec%0d.predict_taken", i),   {31'd0, predict_taken},   {31'd0, vecs[i].e_pt});
            chk($sformatf("vec%0d.predict_target", i),  predict_target,           vecs[i].e_ptgt);
            chk($sformatf("vec%0d.miss_prediction", i), {31'd0, miss_prediction}, {31'd0, vecs[i].e_miss});
            chk($sformatf("vec%0d.correct_pc", i),      correct_pc,               vecs[i].e_cpc);
            @(negedge clk);
        end
        ex_valid = 1'b0;
        chk("vec.branch_cnt", {16'd0, branch_cnt}, 32'd8);
        chk("vec.miss_cnt",   {16'd0, miss_cnt},   32'd4);
`endif

        // Randomized traffic over a small PC window so indexes alias often.
        ex_valid = 1'b0;
        pulse_reset();
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] bpc;
            pc_if     = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
            bpc       = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
            ex_valid  = ($urandom_range(0, 3) != 0);
            ex_pc4    = bpc + 32'd4;
            ex_taken  = $urandom_range(0, 1) == 1;
            ex_target = ($urandom_range(0, 1) == 1) ? m_ptgt(bpc)
                                                    : {20'd0, 10'($urandom), 2'b00};
            if ($urandom_range(0, 3) == 0) begin
                ex_predicted   = $urandom_range(0, 1) == 1;
                ex_pred_target = {20'd0, 10'($urandom), 2'b00};
            end else begin
                ex_predicted   = m_pred(bpc);
                ex_pred_target = m_ptgt(bpc);
            end
            #1;
            check_model($sformatf("rand%0d", i));
            @(posedge clk);
            model_update();
            @(negedge clk);
        end

        // Saturation: every resolution is a forced misprediction.
        ex_valid = 1'b0;
        pulse_reset();
        pc_if = 32'h40; ex_valid = 1'b1; ex_pc4 = 32'h44; ex_taken = 1'b1;
        ex_target = 32'h80; ex_predicted = 1'b0; ex_pred_target = 32'd0;
        repeat (65540) @(posedge clk);
        @(negedge clk);
        chk("sat.branch_cnt",      {16'd0, branch_cnt},      32'hFFFF);
        chk("sat.miss_cnt",        {16'd0, miss_cnt},        32'hFFFF);
        chk("sat.predict_target",  predict_target,           32'h80);
        chk("sat.miss_prediction", {31'd0, miss_prediction}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("midrst.branch_cnt",      {16'd0, branch_cnt},      32'd0);
        chk("midrst.miss_cnt",        {16'd0, miss_cnt},        32'd0);
        chk("midrst.predict_target",  predict_target,           32'd0);
        chk("midrst.predict_taken",   {31'd0, predict_taken},   32'd0);
        chk("midrst.miss_prediction", {31'd0, miss_prediction}, 32'd0);
        @(posedge clk);
        #1;
        chk("midrst_edge.branch_cnt",     {16'd0, branch_cnt}, 32'd0);
        chk("midrst_edge.predict_target", predict_target,      32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst.branch_cnt",     {16'd0, branch_cnt}, 32'd1);
        chk("post_rst.miss_cnt",       {16'd0, miss_cnt},   32'd1);
        chk("post_rst.predict_target", predict_target,      32'h80);
        ex_valid = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- IF-stage direction/target predictor. Drives the predict bit that travels IF_ID -> ID_EX.
- Consumes branch resolution from EX: ID_EX predict bit, PC+4, actual outcome and target.
- Produces the miss-prediction flush (wired to ID_EX/IF_ID flush inputs) and the corrected fetch PC.
- Holds a direct-mapped table of 2-bit saturating counters plus a tagged BTB.

Parameters:
- INDEX_BITS, 6, log2 of table entries (64 entries); index = pc[INDEX_BITS+1:2]
- TAG_BITS, 8, BTB tag width; tag = pc[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2]
- CNT_INIT, 2'b01, counter reset value (weakly not-taken)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- pc_if  in  32  current fetch PC
- predict_taken  out  1  combinational prediction for pc_if
- predict_target  out  32  BTB target for pc_if; 0 when no BTB hit
- ex_valid  in  1  EX holds a resolved conditional branch this cycle
- ex_pc4  in  32  PC+4 of the resolving branch (PC_ID_EX)
- ex_taken  in  1  actual branch outcome
- ex_target  in  32  actual taken target
- ex_predicted  in  1  prediction made at fetch (Predict_Taken_ID_EX)
- ex_pred_target  in  32  target used at fetch when predicted taken
- miss_prediction  out  1  combinational flush request
- correct_pc  out  32  redirect PC, valid when miss_prediction=1
- branch_cnt  out  16  resolved-branch count
- miss_cnt  out  16  misprediction count

Behaviour:
- Reset (async, rst=1):
  - all counters = CNT_INIT; all BTB valid = 0
  - branch_cnt = miss_cnt = 0
  - predict_taken = 0, predict_target = 0, miss_prediction = 0
- Lookup (combinational, zero latency):
  - hit = valid[idx] && tag[idx]==tag(pc_if)
  - predict_taken = hit && cnt[idx][1]
  - predict_target = hit ? target[idx] : 0
- Resolution (combinational):
  - bpc = ex_pc4 - 4; update index and tag are taken from bpc
  - miss_prediction = ex_valid && ((ex_taken != ex_predicted) || (ex_taken && ex_predicted && ex_target != ex_pred_target))
  - correct_pc = ex_taken ? ex_target : ex_pc4
  - ex_valid=0 -> miss_prediction = 0, correct_pc = ex_pc4
- Update (rising edge, ex_valid=1):
  - counter: taken -> +1, saturating at 3; not-taken -> -1, saturating at 0
  - taken: BTB entry written (valid=1, tag, target=ex_target); overwrites any alias
  - not-taken: BTB entry untouched
  - branch_cnt += 1; miss_cnt += miss_prediction; both saturate at 16'hFFFF
- Simultaneous lookup and update of the same index: lookup returns pre-update contents; new values are visible from the next cycle.
- Index wrap: PCs 4*2^INDEX_BITS apart share a counter. The BTB tag disambiguates only the target, not the counter.
- rst asserted mid-resolution: the update is discarded and state is cleared immediately.

Optional Feature:
- Macro: BRANCH_PREDICTOR_GSHARE_EN
- Defined:
  - adds ghr[INDEX_BITS-1:0] (global history register), reset to 0
  - counter index = pc index XOR ghr, for both lookup and update; the update uses ghr before the shift
  - on each ex_valid edge: ghr <= {ghr[INDEX_BITS-2:0], ex_taken}
  - BTB still uses the un-hashed index
- Undefined: no ghr; counters are indexed by PC bits only.

Test Plan:
- Reset release, pc_if=0x40 -> predict_taken=0, predict_target=0, branch_cnt=miss_cnt=0.
- Branch at 0x40 (ex_pc4=0x44) resolved taken to 0x80, ex_predicted=0 -> miss_prediction=1, correct_pc=0x80. Next cycle pc_if=0x40 -> predict_target=0x80, predict_taken=1 (counter 2).
- Four consecutive taken resolutions at 0x40, then one not-taken with ex_predicted=1 -> miss_prediction=1, correct_pc=0x44, counter 3->2, predict_taken still 1.
- Predicted taken to 0x80 but actual target 0xC0 -> miss_prediction=1, correct_pc=0xC0, BTB target becomes 0xC0.
- Aliased PC 0x140 (same index, different tag) looked up after 0x40 trained -> predict_taken=0, predict_target=0.
- Drive 65540 resolutions with forced mispredictions -> branch_cnt and miss_cnt hold 16'hFFFF; asserting rst mid-stream clears both the same cycle.
